// File: rtl/spr_pkg.sv
// Shared sizing and types for the single-port RAM.
// Holds DATA_W/ADDR_W/DEPTH and the data_t/addr_t typedefs.
package spr_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/modport_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read.
// Ports: clk, rst (async high), din, we, rd, addr -> dout.
module modport_ram
  import spr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  data_t din,
  input  logic  we,
  input  logic  rd,
  input  addr_t addr,
  output data_t dout
);

  // Flop array rather than a RAM macro so reset can clear it asynchronously.
  data_t mem [DEPTH];
  logic  in_range;

  // Only a partially populated address space needs a range check.
  generate
    if (DEPTH < 2**ADDR_W) begin : g_part
      assign in_range = 32'(addr) < DEPTH;
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  // An unknown we/rd falls to the not-taken branch, so it acts as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we) begin
        if (in_range) begin
          mem[addr] <= din;
        end
      end
      if (rd) begin
        if (we) begin
          // Write-through: the new data appears on dout the same edge.
          dout <= din;
        end else if (in_range) begin
          dout <= mem[addr];
        end else begin
          dout <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_modport_ram.sv
// Directed self-checking bench for modport_ram.
// Linear stimulus; every comparison is an immediate assertion.
module tb_modport_ram;
  import spr_pkg::*;

  logic  clk;
  logic  rst;
  data_t din;
  logic  we;
  logic  rd;
  addr_t addr;
  data_t dout;

  int checks;
  int passed;

  modport_ram dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .we   (we),
    .rd   (rd),
    .addr (addr),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input data_t got,
                     input data_t exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: dout=%h expected=%h", tag, got, exp);
  endtask

  task automatic do_write(input addr_t a, input data_t d);
    addr = a;
    din  = d;
    we   = 1'b1;
    rd   = 1'b0;
    tick();
    we   = 1'b0;
  endtask

  task automatic do_read(input string tag,
                         input addr_t a,
                         input data_t exp);
    addr = a;
    we   = 1'b0;
    rd   = 1'b1;
    tick();
    rd   = 1'b0;
    chk(tag, dout, exp);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst  = 1'b1;
    we   = 1'b0;
    rd   = 1'b0;
    din  = '0;
    addr = '0;

    tick();
    tick();
    chk("reset_dout", dout, 8'h00);
    rst = 1'b0;

    do_read("rst_rd0", 6'd0, 8'h00);
    do_read("rst_rd31", 6'd31, 8'h00);
    do_read("rst_rd63", 6'd63, 8'h00);

    do_write(6'd3, 8'hA5);
    do_read("rd3", 6'd3, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      addr = 6'(i + 20);
      tick();
      chk("hold3", dout, 8'hA5);
    end

    do_write(6'd0, 8'h11);
    do_write(6'd63, 8'hEE);
    do_read("rd0", 6'd0, 8'h11);
    do_read("rd63", 6'd63, 8'hEE);
    do_read("rd1", 6'd1, 8'h00);

    addr = 6'd10;
    din  = 8'h5C;
    we   = 1'b1;
    rd   = 1'b1;
    tick();
    we   = 1'b0;
    rd   = 1'b0;
    chk("wthru", dout, 8'h5C);
    do_read("wthru_rd", 6'd10, 8'h5C);

    addr = 6'd7;
    din  = 8'hFF;
    we   = 1'bx;
    rd   = 1'bx;
    tick();
    we   = 1'b0;
    rd   = 1'b0;
    chk("x_nord", dout, 8'h5C);
    do_read("x_nowr", 6'd7, 8'h00);

    for (int k = 0; k < DEPTH; k++) begin
      do_write(6'(k), 8'(k) ^ 8'hFF);
    end
    for (int k = 0; k < DEPTH; k++) begin
      do_read("b2b", 6'(k), 8'(k) ^ 8'hFF);
    end

    do_write(6'd5, 8'h77);
    do_read("rd5", 6'd5, 8'h77);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", dout, 8'h00);
    #1;
    rst = 1'b0;
    tick();
    do_read("mid_rd5", 6'd5, 8'h00);
    do_read("mid_rd63", 6'd63, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
